// File: rtl/anneal_scheduler.sv
// Annealing sequencer for the sparse p-bit multiplier array: clear, phased sweeps, sample, handoff.
// Define ANNEAL_SCHEDULER_ABORT_EN to add an abort_i input that cancels a run in flight.
//
// state   | meaning
// IDLE    | waiting for start_i
// CLEAR   | pbit_reset held for CLEAR_CYCLES cycles
// ANNEAL  | one-hot phase enables rotate, bit_shift ramps up to MAX_SHIFT
// SAMPLE  | one settle cycle with all phases off, product captured at its end
// HOLD    | sample_valid presented until the consumer accepts it
module anneal_scheduler #(
  parameter int N_BITS          = 8,
  parameter int N_PHASES        = 5,
  parameter int SWEEPS_PER_STEP = 16,
  parameter int CLEAR_CYCLES    = 2,
  parameter int MAX_SHIFT       = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
`ifdef ANNEAL_SCHEDULER_ABORT_EN
  input  logic                abort_i,
`endif
  output logic                pbit_reset_o,
  output logic [N_PHASES-1:0] phase_en_o,
  output logic [1:0]          bit_shift_o,
  input  logic [N_BITS-1:0]   product_i,
  output logic [N_BITS-1:0]   sample_data_o,
  output logic                sample_valid_o,
  input  logic                sample_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam int SWP_W = $clog2(SWEEPS_PER_STEP + 1);
  localparam logic [1:0]          MAX_SHIFT_V = 2'(MAX_SHIFT);
  localparam logic [CLR_W-1:0]    CLR_LOAD    = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [SWP_W-1:0]    SWP_LOAD    = SWP_W'(SWEEPS_PER_STEP - 1);
  localparam logic [N_PHASES-1:0] PHASE_FIRST = N_PHASES'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ANNEAL,
    S_SAMPLE,
    S_HOLD
  } state_e;

  state_e              state_q;
  logic [CLR_W-1:0]    clear_cnt_q;
  logic [SWP_W-1:0]    sweep_cnt_q;
  logic                pbit_reset_q;
  logic [N_PHASES-1:0] phase_en_q;
  logic [1:0]          bit_shift_q;
  logic [N_BITS-1:0]   sample_data_q;
  logic                sample_valid_q;
  logic                busy_q;
  logic                done_q;
  logic                abort_w;

`ifdef ANNEAL_SCHEDULER_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      clear_cnt_q    <= '0;
      sweep_cnt_q    <= '0;
      pbit_reset_q   <= 1'b0;
      phase_en_q     <= '0;
      bit_shift_q    <= '0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else if (abort_w && (state_q == S_CLEAR || state_q == S_ANNEAL ||
                             state_q == S_SAMPLE)) begin
      // sample_data is deliberately left untouched so the last good product survives
      state_q        <= S_IDLE;
      clear_cnt_q    <= '0;
      sweep_cnt_q    <= '0;
      pbit_reset_q   <= 1'b0;
      phase_en_q     <= '0;
      bit_shift_q    <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q      <= S_CLEAR;
            pbit_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            clear_cnt_q  <= CLR_LOAD;
          end
        end
        S_CLEAR: begin
          if (clear_cnt_q == '0) begin
            state_q      <= S_ANNEAL;
            pbit_reset_q <= 1'b0;
            phase_en_q   <= PHASE_FIRST;
            sweep_cnt_q  <= SWP_LOAD;
          end else begin
            clear_cnt_q <= clear_cnt_q - CLR_W'(1);
          end
        end
        S_ANNEAL: begin
          if (phase_en_q[N_PHASES-1]) begin
            if (sweep_cnt_q != '0) begin
              sweep_cnt_q <= sweep_cnt_q - SWP_W'(1);
              phase_en_q  <= PHASE_FIRST;
            end else if (bit_shift_q < MAX_SHIFT_V) begin
              // new temperature lands together with phase 0 of the next sweep
              bit_shift_q <= bit_shift_q + 2'd1;
              sweep_cnt_q <= SWP_LOAD;
              phase_en_q  <= PHASE_FIRST;
            end else begin
              state_q    <= S_SAMPLE;
              phase_en_q <= '0;
            end
          end else begin
            phase_en_q <= phase_en_q << 1;
          end
        end
        S_SAMPLE: begin
          state_q        <= S_HOLD;
          sample_data_q  <= product_i;
          sample_valid_q <= 1'b1;
        end
        S_HOLD: begin
          if (sample_ready_i) begin
            state_q        <= S_IDLE;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b1;
            busy_q         <= 1'b0;
            bit_shift_q    <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pbit_reset_o   = pbit_reset_q;
  assign phase_en_o     = phase_en_q;
  assign bit_shift_o    = bit_shift_q;
  assign sample_data_o  = sample_data_q;
  assign sample_valid_o = sample_valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_anneal_scheduler.sv
// Directed bench for anneal_scheduler; expected products are queued at drive time and
// popped at the valid/ready handshake. Abort scenario runs when ANNEAL_SCHEDULER_ABORT_EN is set.
module tb_anneal_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic       abort_i;
  logic       pbit_reset_o;
  logic [4:0] phase_en_o;
  logic [1:0] bit_shift_o;
  logic [7:0] product_i;
  logic [7:0] sample_data_o;
  logic       sample_valid_o;
  logic       sample_ready_i;
  logic       busy_o;
  logic       done_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sb_q[$];

  anneal_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
`ifdef ANNEAL_SCHEDULER_ABORT_EN
    .abort_i       (abort_i),
`endif
    .pbit_reset_o  (pbit_reset_o),
    .phase_en_o    (phase_en_o),
    .bit_shift_o   (bit_shift_o),
    .product_i     (product_i),
    .sample_data_o (sample_data_o),
    .sample_valid_o(sample_valid_o),
    .sample_ready_i(sample_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {pbit_reset, phase_en[4:0], bit_shift[1:0], sample_valid, done, busy}
  function automatic logic [10:0] obs_vec();
    return {pbit_reset_o, phase_en_o, bit_shift_o, sample_valid_o, done_o, busy_o};
  endfunction

  // Expected control outputs for cycle c of a default run (start sampled in cycle 0, no stall).
  function automatic logic [10:0] exp_vec(input int c);
    logic       pb;
    logic [4:0] ph;
    logic [1:0] sh;
    logic       vl;
    logic       bz;
    int         step;
    pb = 1'b0; ph = '0; sh = '0; vl = 1'b0; bz = 1'b0;
    if (c >= 1 && c <= 2) begin
      pb = 1'b1; bz = 1'b1;
    end else if (c >= 3 && c <= 322) begin
      ph   = 5'd1 << ((c - 3) % 5);
      step = (c - 3) / 80;
      sh   = 2'(step);
      bz   = 1'b1;
    end else if (c == 323) begin
      sh = 2'd3; bz = 1'b1;
    end else if (c == 324) begin
      sh = 2'd3; vl = 1'b1; bz = 1'b1;
    end
    return {pb, ph, sh, vl, 1'b0, bz};
  endfunction

  // Drives start in cycle 0 and checks cycles 1..upto against the reference schedule.
  task automatic run_checked(input int upto, input string tag);
    start_i = 1'b1;
    for (int c = 1; c <= upto; c++) begin
      tick();
      start_i = 1'b0;
      check($sformatf("%s_c%0d", tag, c), 32'(obs_vec()), 32'(exp_vec(c)));
    end
  endtask

  task automatic pop_and_check(input string tag);
    logic [7:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(tag, 32'(sample_data_o), 32'(e));
    end
  endtask

  initial begin
    int done_cnt;
    logic [10:0] acc;

    reset = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    product_i = '0; sample_ready_i = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // reset and idle
    check("reset_ctrl", 32'(obs_vec()), 32'd0);
    check("reset_data", 32'(sample_data_o), 32'd0);
    acc = '0;
    for (int i = 0; i < 50; i++) begin
      tick();
      acc |= obs_vec();
    end
    check("idle_quiet", 32'(acc), 32'd0);

    // full run, start also asserted during the HOLD handshake cycle
    product_i = 8'hA5; sb_q.push_back(8'hA5);
    run_checked(324, "run1");
    pop_and_check("run1_data");
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("run1_done", 32'(obs_vec()), 32'(11'b000000_00_010));
    tick();
    check("run1_after", 32'(obs_vec()), 32'd0);
    tick();
    check("run1_no_restart", 32'(obs_vec()), 32'd0);

    // backpressure
    sample_ready_i = 1'b0;
    product_i = 8'hA5; sb_q.push_back(8'hA5);
    run_checked(324, "bp");
    product_i = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_hold_ctrl%0d", i), 32'(obs_vec()), 32'(11'b000000_11_101));
      check($sformatf("bp_hold_data%0d", i), 32'(sample_data_o), 32'hA5);
    end
    sample_ready_i = 1'b1;
    pop_and_check("bp_data");
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_o) done_cnt++;
      if (i == 0) check("bp_done", 32'(obs_vec()), 32'(11'b000000_00_010));
    end
    check("bp_done_count", 32'(done_cnt), 32'd1);

    // start while busy is ignored
    product_i = 8'h77; sb_q.push_back(8'h77);
    start_i = 1'b1;
    for (int c = 1; c <= 324; c++) begin
      tick();
      start_i = (c == 100);
      if (c == 1 || c == 100 || c == 101 || c == 324)
        check($sformatf("busy_start_c%0d", c), 32'(obs_vec()), 32'(exp_vec(c)));
    end
    start_i = 1'b0;
    pop_and_check("busy_start_data");
    done_cnt = 0;
    acc = '0;
    for (int c = 325; c <= 420; c++) begin
      tick();
      if (done_o) done_cnt++;
      if (c > 325) acc |= obs_vec();
    end
    check("busy_start_dones", 32'(done_cnt), 32'd1);
    check("busy_start_quiet", 32'(acc), 32'd0);

    // reset mid-run, then a complete run
    product_i = 8'h11;
    run_checked(150, "midrst");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ctrl", 32'(obs_vec()), 32'd0);
    check("midrst_data", 32'(sample_data_o), 32'd0);
    tick();
    product_i = 8'h5A; sb_q.push_back(8'h5A);
    run_checked(324, "rerun");
    pop_and_check("rerun_data");
    tick();
    check("rerun_done", 32'(obs_vec()), 32'(11'b000000_00_010));
    tick();

`ifdef ANNEAL_SCHEDULER_ABORT_EN
    product_i = 8'hC3;
    run_checked(200, "abort");
    abort_i = 1'b1;
    start_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    check("abort_ctrl", 32'(obs_vec()), 32'd0);
    check("abort_data", 32'(sample_data_o), 32'h5A);
    acc = '0;
    for (int i = 0; i < 200; i++) begin
      tick();
      acc |= obs_vec();
    end
    check("abort_quiet", 32'(acc), 32'd0);
`endif

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
